spi_deser_multi: RTL

Parametrised multi-lane serial-to-parallel deserialiser for the WiMAX datapath front end. It collects `PARALLEL_WIDTH` bits over `LANES` serial lanes and supports LSB-first or MSB-first ordering. Completed words are presented on a valid/ready output port through a single holding register. Mid-frame aborts and overflows are detected and reported. Frames may arrive back-to-back with no dead cycle.

---
 rtl/spi_deser_multi.sv | 76 +++++++
 1 files changed

// File: rtl/spi_deser_multi.sv
// spi_deser_multi: multi-lane serial-to-parallel deserialiser with valid/ready output, abort and overflow reporting
module spi_deser_multi #(
  parameter int PARALLEL_WIDTH = 96,
  parameter int LANES = 1,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      serial_ready,
  input  logic [LANES-1:0]          serial_in,
  input  logic                      parallel_ready,
  output logic                      parallel_valid,
  output logic [PARALLEL_WIDTH-1:0] parallel_out,
  output logic                      frame_abort,
  output logic                      overflow,
  input  logic                      clear_overflow,
  output logic [CNT_WIDTH-1:0]      frame_count
);
  localparam int BEATS = PARALLEL_WIDTH / LANES;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic {IDLE, COLLECT} state_e;
  state_e state_q;
  logic [BW-1:0] beat_cnt_q, k;
  logic [PARALLEL_WIDTH-1:0] shift_q, word_d, out_q;
  logic valid_q, abort_q, ovf_q, last, load, hs;
  logic [CNT_WIDTH-1:0] cnt_q;
  int pos;
  // insert the current beat into the word and decide completion, load and handshake
  always_comb begin
    k = state_q == IDLE ? '0 : beat_cnt_q;
    pos = LSB_FIRST ? int'(k) * LANES : PARALLEL_WIDTH - (int'(k) + 1) * LANES;
    word_d = shift_q;
    word_d[pos +: LANES] = serial_in;
    last = k == BW'(BEATS - 1);
    hs = valid_q && parallel_ready;
    load = serial_ready && last && (!valid_q || parallel_ready);
  end
  // FSM, shift register, holding register, abort pulse, overflow flag and frame counter
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      beat_cnt_q <= '0;
      shift_q <= '0;
      out_q <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      abort_q <= state_q == COLLECT && !serial_ready;
      if (serial_ready) begin
        shift_q <= word_d;
        state_q <= last ? IDLE : COLLECT;
        beat_cnt_q <= last ? '0 : k + 1'b1;
      end else begin
        state_q <= IDLE;
        beat_cnt_q <= '0;
      end
      if (load) begin
        out_q <= word_d;
        valid_q <= 1'b1;
        cnt_q <= cnt_q + 1'b1;
      end else if (hs) begin
        valid_q <= 1'b0;
      end
      if (serial_ready && last && !load) ovf_q <= 1'b1;
      else if (clear_overflow) ovf_q <= 1'b0;
    end
  end
  assign parallel_valid = valid_q;
  assign parallel_out = out_q;
  assign frame_abort = abort_q;
  assign overflow = ovf_q;
  assign frame_count = cnt_q;
endmodule
